// File: rtl/traffic_pkg.sv
// Shared state/lamp encodings, default phase durations and lamp decode helpers
// for the traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int DEF_GREEN_TICKS  = 5;
  localparam int DEF_MIN_GREEN    = 2;
  localparam int DEF_YELLOW_TICKS = 2;
  localparam int DEF_RED_TICKS    = 1;
  localparam int DEF_WALK_TICKS   = 3;

  function automatic state_t next_state(input state_t s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return RED_A;
      RED_A:     return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return RED_B;
      default:   return NS_GREEN;
    endcase
  endfunction

  function automatic logic [2:0] ns_lamp(input state_t s);
    case (s)
      NS_GREEN:  return GRN;
      NS_YELLOW: return YEL;
      default:   return RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input state_t s);
    case (s)
      EW_GREEN:  return GRN;
      EW_YELLOW: return YEL;
      default:   return RED;
    endcase
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the divided slow clock; resets the history to 1 so
// a level held high through reset never produces a tick.
module tick_edge_detect (
  input  logic i_clock,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic sig_prev_d;
  logic sig_prev_q;

  always_comb begin
    sig_prev_d = i_sig;
  end

  always_ff @(posedge i_clock) begin
    if (reset) begin
      sig_prev_q <= 1'b1;
    end else begin
      sig_prev_q <= sig_prev_d;
    end
  end

  assign o_rise = i_sig & ~sig_prev_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-way intersection controller with pedestrian walk phase, timed in ticks
// of an external slow clock.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int MIN_GREEN    = DEF_MIN_GREEN,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int RED_TICKS    = DEF_RED_TICKS,
  parameter int WALK_TICKS   = DEF_WALK_TICKS
) (
  input  logic       i_clock,
  input  logic       reset,
  input  logic       i_slow_clk,
  input  logic       i_ped_req,
  output logic [2:0] o_ns_light,
  output logic [2:0] o_ew_light,
  output logic       o_walk,
  output logic [2:0] o_state
);

  logic       tick;
  state_t     state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic       ped_pending_d, ped_pending_q;
  logic       walk_phase_d, walk_phase_q;
  logic [2:0] ns_light_d, ns_light_q;
  logic [2:0] ew_light_d, ew_light_q;
  logic [3:0] duration;

  tick_edge_detect u_tick (
    .i_clock (i_clock),
    .reset   (reset),
    .i_sig   (i_slow_clk),
    .o_rise  (tick)
  );

  // Decisions use the registered pending flag, so a request arriving on a
  // tick cycle only shortens a later tick's evaluation.
  always_comb begin
    case (state_q)
      NS_GREEN, EW_GREEN:   duration = ped_pending_q ? 4'(MIN_GREEN) : 4'(GREEN_TICKS);
      NS_YELLOW, EW_YELLOW: duration = 4'(YELLOW_TICKS);
      default:              duration = walk_phase_q ? 4'(WALK_TICKS) : 4'(RED_TICKS);
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ped_pending_d = ped_pending_q | i_ped_req;
    walk_phase_d  = walk_phase_q;
    if (tick) begin
      if (cnt_q >= duration - 4'd1) begin
        state_d = next_state(state_q);
        cnt_d   = 4'd0;
        if (state_d == RED_A || state_d == RED_B) begin
          walk_phase_d = ped_pending_q;
          if (ped_pending_q) begin
            ped_pending_d = i_ped_req;
          end
        end else begin
          walk_phase_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    ns_light_d = ns_lamp(state_d);
    ew_light_d = ew_lamp(state_d);
  end

  // Lamps are registered from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge i_clock) begin
    if (reset) begin
      state_q       <= RED_B;
      cnt_q         <= 4'd0;
      ped_pending_q <= 1'b0;
      walk_phase_q  <= 1'b0;
      ns_light_q    <= RED;
      ew_light_q    <= RED;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      walk_phase_q  <= walk_phase_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
    end
  end

  assign o_ns_light = ns_light_q;
  assign o_ew_light = ew_light_q;
  assign o_walk     = walk_phase_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed scenarios plus a randomized safety sweep for traffic_light_fsm.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       slow = 1'b0;
  logic       req = 1'b0;
  logic [2:0] ns;
  logic [2:0] ew;
  logic       walk;
  logic [2:0] state;

  int vectors = 0;
  int errors  = 0;

  traffic_light_fsm dut (
    .i_clock    (clk),
    .reset      (reset),
    .i_slow_clk (slow),
    .i_ped_req  (req),
    .o_ns_light (ns),
    .o_ew_light (ew),
    .o_walk     (walk),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_lamps(input state_t s);
    case (s)
      NS_GREEN:  return {3'b001, 3'b100};
      NS_YELLOW: return {3'b010, 3'b100};
      EW_GREEN:  return {3'b100, 3'b001};
      EW_YELLOW: return {3'b100, 3'b010};
      default:   return {3'b100, 3'b100};
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One slow-clock rising edge; r is driven on the same cycle as the tick.
  task automatic do_tick(input logic r);
    @(negedge clk);
    slow = 1'b1;
    req  = r;
    @(negedge clk);
    slow = 1'b0;
    req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset();
    slow = 1'b0;
    do_reset();
    vectors++;
    if (state !== RED_B) begin
      $display("[TB] FAIL reset_state got=%0d want=%0d", state, RED_B); errors++;
    end
    vectors++;
    if ({ns, ew} !== 6'b100100) begin
      $display("[TB] FAIL reset_lamps got=%b want=100100", {ns, ew}); errors++;
    end
    vectors++;
    if (walk !== 1'b0) begin
      $display("[TB] FAIL reset_walk got=%b want=0", walk); errors++;
    end
  endtask

  task automatic test_sequence();
    state_t exp_seq [20] = '{NS_GREEN, NS_GREEN, NS_GREEN, NS_GREEN, NS_GREEN,
                             NS_YELLOW, NS_YELLOW, RED_A,
                             EW_GREEN, EW_GREEN, EW_GREEN, EW_GREEN, EW_GREEN,
                             EW_YELLOW, EW_YELLOW, RED_B,
                             NS_GREEN, NS_GREEN, NS_GREEN, NS_GREEN};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_tick(1'b0);
      vectors++;
      if (state !== exp_seq[i] || {ns, ew} !== exp_lamps(exp_seq[i]) || walk !== 1'b0) begin
        $display("[TB] FAIL seq_tick%0d got state=%0d lamps=%b walk=%b want state=%0d lamps=%b walk=0",
                 i + 1, state, {ns, ew}, walk, exp_seq[i], exp_lamps(exp_seq[i]));
        errors++;
      end
    end
  endtask

  task automatic test_ped_walk();
    state_t exp_st [7] = '{NS_GREEN, NS_YELLOW, NS_YELLOW, RED_A, RED_A, RED_A, EW_GREEN};
    logic   exp_wk [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    do_tick(1'b0);
    pulse_req();
    for (int i = 0; i < 7; i++) begin
      do_tick(1'b0);
      vectors++;
      if (state !== exp_st[i] || walk !== exp_wk[i] || {ns, ew} !== exp_lamps(exp_st[i])) begin
        $display("[TB] FAIL ped_tick%0d got state=%0d walk=%b lamps=%b want state=%0d walk=%b lamps=%b",
                 i + 2, state, walk, {ns, ew}, exp_st[i], exp_wk[i], exp_lamps(exp_st[i]));
        errors++;
      end
    end
    repeat (4) do_tick(1'b0);
    vectors++;
    if (state !== EW_GREEN) begin
      $display("[TB] FAIL ped_ew_full_green got=%0d want=%0d", state, EW_GREEN); errors++;
    end
    do_tick(1'b0);
    vectors++;
    if (state !== EW_YELLOW) begin
      $display("[TB] FAIL ped_ew_yellow got=%0d want=%0d", state, EW_YELLOW); errors++;
    end
  endtask

  task automatic test_coincident();
    do_reset();
    repeat (3) do_tick(1'b0);
    do_tick(1'b1);
    vectors++;
    if (state !== NS_GREEN) begin
      $display("[TB] FAIL coinc_no_transition got=%0d want=%0d", state, NS_GREEN); errors++;
    end
    do_tick(1'b0);
    vectors++;
    if (state !== NS_YELLOW) begin
      $display("[TB] FAIL coinc_yellow got=%0d want=%0d", state, NS_YELLOW); errors++;
    end
    do_tick(1'b0);
    do_tick(1'b0);
    vectors++;
    if (state !== RED_A || walk !== 1'b1) begin
      $display("[TB] FAIL coinc_walk got state=%0d walk=%b want state=%0d walk=1", state, walk, RED_A);
      errors++;
    end
  endtask

  task automatic test_slow_high();
    @(negedge clk);
    slow  = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (state !== RED_B) begin
      $display("[TB] FAIL slowhigh_hold got=%0d want=%0d", state, RED_B); errors++;
    end
    slow = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (state !== RED_B) begin
      $display("[TB] FAIL slowhigh_fall got=%0d want=%0d", state, RED_B); errors++;
    end
    do_tick(1'b0);
    vectors++;
    if (state !== NS_GREEN) begin
      $display("[TB] FAIL slowhigh_first_tick got=%0d want=%0d", state, NS_GREEN); errors++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (14) do_tick(1'b0);
    vectors++;
    if (state !== EW_YELLOW) begin
      $display("[TB] FAIL mid_reach_ewy got=%0d want=%0d", state, EW_YELLOW); errors++;
    end
    pulse_req();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({ns, ew} !== 6'b100100 || walk !== 1'b0 || state !== RED_B) begin
      $display("[TB] FAIL mid_reset got lamps=%b walk=%b state=%0d want lamps=100100 walk=0 state=%0d",
               {ns, ew}, walk, state, RED_B);
      errors++;
    end
    do_tick(1'b0);
    vectors++;
    if (state !== NS_GREEN || walk !== 1'b0) begin
      $display("[TB] FAIL mid_redb_len got state=%0d walk=%b want state=%0d walk=0", state, walk, NS_GREEN);
      errors++;
    end
    repeat (4) do_tick(1'b0);
    vectors++;
    if (state !== NS_GREEN) begin
      $display("[TB] FAIL mid_full_green got=%0d want=%0d", state, NS_GREEN); errors++;
    end
    repeat (3) do_tick(1'b0);
    vectors++;
    if (state !== RED_A || walk !== 1'b0) begin
      $display("[TB] FAIL mid_reda_nowalk got state=%0d walk=%b want state=%0d walk=0", state, walk, RED_A);
      errors++;
    end
    do_tick(1'b0);
    vectors++;
    if (state !== EW_GREEN) begin
      $display("[TB] FAIL mid_reda_len got=%0d want=%0d", state, EW_GREEN); errors++;
    end
  endtask

  task automatic test_random();
    int walk_seen = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req  = ($urandom_range(0, 5) == 0);
      slow = ((c % 6) >= 3);
      @(posedge clk);
      #1;
      if (walk === 1'b1) walk_seen++;
      vectors++;
      if ((ns !== 3'b100 && ew !== 3'b100) || !$onehot(ns) || !$onehot(ew) ||
          (walk === 1'b1 && state !== RED_A && state !== RED_B)) begin
        $display("[TB] FAIL random_safety cycle=%0d got ns=%b ew=%b walk=%b state=%0d want one red side, one-hot lamps, walk only in all-red",
                 c, ns, ew, walk, state);
        errors++;
      end
    end
    req  = 1'b0;
    slow = 1'b0;
    vectors++;
    if (walk_seen == 0) begin
      $display("[TB] FAIL random_walk_exercised got=%0d walk cycles want>0", walk_seen); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ped_walk();
    test_coincident();
    test_slow_high();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
